// File: rtl/onchip_mem_bist_pkg.sv
// Shared defaults, FSM state encoding and the test-pattern generator for the
// on-chip memory BIST master.
package onchip_mem_bist_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 16000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  // Upper half is seed^addr, lower half its complement, so every bit toggles.
  function automatic logic [63:0] bist_pattern(input logic [31:0] seed,
                                               input logic [31:0] addr);
    logic [31:0] x;
    x = seed ^ addr;
    return {x, ~x};
  endfunction

endpackage

// File: rtl/onchip_mem_bist_cmp.sv
// Read-data checker: registers the expected word alongside each read command
// and compares it with the slave data one cycle later.
module onchip_mem_bist_cmp
  import onchip_mem_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       seed_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W:0]   err_count_o,
  output logic              first_err_valid_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] eaddr_q;
  logic [ADDR_W:0]   err_q;
  logic              fev_q;
  logic [ADDR_W-1:0] fea_q;
  logic              miss_d;

  assign miss_d = vld_q && (rdata_i != exp_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q   <= 1'b0;
      exp_q   <= '0;
      eaddr_q <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
    end else begin
      vld_q <= rd_i;
      if (rd_i) begin
        exp_q   <= DATA_W'(bist_pattern(seed_i, 32'(addr_i)));
        eaddr_q <= addr_i;
      end
      if (clear_i) begin
        err_q <= '0;
        fev_q <= 1'b0;
      end else if (miss_d) begin
        err_q <= err_q + (ADDR_W+1)'(1);
        if (!fev_q) begin
          fev_q <= 1'b1;
          fea_q <= eaddr_q;
        end
      end
    end
  end

  assign err_count_o       = err_q;
  assign first_err_valid_o = fev_q;
  assign first_err_addr_o  = fea_q;

endmodule

// File: rtl/onchip_mem_bist_master.sv
// BIST master for an Avalon-MM on-chip RAM: optional pattern fill over a window,
// then read-back and compare, reporting miscompare count and first failing address.
module onchip_mem_bist_master
  import onchip_mem_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     length,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [ADDR_W:0]     err_count,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [ADDR_W:0]   len_q, cnt_q;
  logic [31:0]       seed_q;
  logic              cfg_err_q;

  logic              accept, len_zero, cfg_bad, last;
  logic [ADDR_W+1:0] end_sum;

  assign accept   = (state_q == ST_IDLE) && start;
  assign len_zero = (length == '0);
  // One extra bit so base+length never wraps before the bound check.
  assign end_sum  = {2'b00, base} + {1'b0, length};
  assign cfg_bad  = end_sum > (ADDR_W+2)'(DEPTH);
  assign last     = (cnt_q == (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) begin
        if (len_zero || cfg_bad) state_d = ST_DONE;
        else if (mode)           state_d = ST_READ;
        else                     state_d = ST_WRITE;
      end
      ST_WRITE: if (last) state_d = ST_READ;
      ST_READ:  if (last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      cfg_err_q <= 1'b0;
    end else if (accept) begin
      base_q    <= base;
      addr_q    <= base;
      len_q     <= length;
      cnt_q     <= length;
      seed_q    <= seed;
      cfg_err_q <= !len_zero && cfg_bad;
    end else if (state_q == ST_WRITE && last) begin
      // Rewind to the window start for the read-back pass.
      addr_q <= base_q;
      cnt_q  <= len_q;
    end else if (state_q == ST_WRITE || state_q == ST_READ) begin
      addr_q <= addr_q + ADDR_W'(1);
      cnt_q  <= cnt_q - (ADDR_W+1)'(1);
    end
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_address    = '0;
    mem_writedata  = '0;
    case (state_q)
      ST_WRITE: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = '1;
        mem_address    = addr_q;
        mem_writedata  = DATA_W'(bist_pattern(seed_q, 32'(addr_q)));
      end
      ST_READ: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_byteenable = '1;
        mem_address    = addr_q;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_clken = 1'b1;
  assign cfg_err   = cfg_err_q;

  onchip_mem_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk               (clk),
    .reset_n           (reset_n),
    .clear_i           (accept),
    .rd_i              (state_q == ST_READ),
    .addr_i            (addr_q),
    .seed_i            (seed_q),
    .rdata_i           (mem_readdata),
    .err_count_o       (err_count),
    .first_err_valid_o (first_err_valid),
    .first_err_addr_o  (first_err_addr)
  );

endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// Directed bench for onchip_mem_bist_master against a 1-cycle-latency RAM model.
module tb_onchip_mem_bist_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [13:0] base = '0;
  logic [14:0] length = '0;
  logic [31:0] seed = '0;
  logic        busy, done, cfg_err, first_err_valid;
  logic [14:0] err_count;
  logic [13:0] first_err_addr, mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata = '0;

  logic [63:0] mem [0:16383];
  logic        flip_en = 1'b0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [13:0] last_rd = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onchip_mem_bist_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .base(base),
    .length(length), .seed(seed), .busy(busy), .done(done), .cfg_err(cfg_err),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_addr(first_err_addr), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // RAM model; optional bit-3 corruption on reads of addresses 5 and 9.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      mem[mem_address] <= mem_writedata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_chipselect && !mem_write) begin
      rd_cnt  <= rd_cnt + 1;
      last_rd <= mem_address;
    end
    mem_readdata <= mem[mem_address] ^
      ((flip_en && (mem_address == 14'd5 || mem_address == 14'd9)) ? 64'h8 : 64'h0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns the cycle index (1 = first cycle after the
  // accepting edge) at which done is seen, with an optional start pulse at 'poke'.
  task automatic run(input logic m, input logic [13:0] b, input logic [14:0] l,
                     input logic [31:0] s, input int poke, output int cyc);
    mode = m; base = b; length = l; seed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        start = 1'b1; mode = 1'b0; base = 14'd200; seed = 32'h0;
      end else start = 1'b0;
    end while (!done && cyc < 1000);
    chk("done_seen", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  int cyc, w0, r0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cs", 64'(mem_chipselect), 64'd0);
    chk("rst_we", 64'(mem_write), 64'd0);
    chk("rst_be", 64'(mem_byteenable), 64'd0);
    chk("rst_addr", 64'(mem_address), 64'd0);
    chk("rst_clken", 64'(mem_clken), 64'd1);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    chk("rst_cfgerr", 64'(cfg_err), 64'd0);
    chk("rst_fev", 64'(first_err_valid), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean fill and check
    w0 = wr_cnt; r0 = rd_cnt;
    run(1'b0, 14'd0, 15'd16, 32'hA5A5A5A5, -1, cyc);
    chk("a_cycles", 64'(cyc), 64'd34);
    chk("a_writes", 64'(wr_cnt - w0), 64'd16);
    chk("a_reads", 64'(rd_cnt - r0), 64'd16);
    chk("a_errcnt", 64'(err_count), 64'd0);
    chk("a_fev", 64'(first_err_valid), 64'd0);
    chk("a_pattern3", mem[3], 64'hA5A5A5A6_5A5A5A59);
    chk("a_pattern15", mem[15], 64'hA5A5A5AA_5A5A5A55);

    // Injected read corruption at addresses 5 and 9
    flip_en = 1'b1;
    run(1'b0, 14'd0, 15'd16, 32'hA5A5A5A5, -1, cyc);
    flip_en = 1'b0;
    chk("b_cycles", 64'(cyc), 64'd34);
    chk("b_errcnt", 64'(err_count), 64'd2);
    chk("b_fev", 64'(first_err_valid), 64'd1);
    chk("b_fea", 64'(first_err_addr), 64'd5);

    // Window overruns the memory
    w0 = wr_cnt; r0 = rd_cnt;
    run(1'b0, 14'd15990, 15'd11, 32'h1, -1, cyc);
    chk("c_cycles", 64'(cyc), 64'd1);
    chk("c_cfgerr", 64'(cfg_err), 64'd1);
    chk("c_errcnt_clr", 64'(err_count), 64'd0);
    chk("c_fev_clr", 64'(first_err_valid), 64'd0);
    chk("c_access", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);

    // Zero length
    run(1'b0, 14'd0, 15'd0, 32'h1, -1, cyc);
    chk("d_cycles", 64'(cyc), 64'd1);
    chk("d_cfgerr", 64'(cfg_err), 64'd0);
    chk("d_access", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);

    // Fill up to the last word, then single read of DEPTH-1
    run(1'b0, 14'd15990, 15'd10, 32'h12345678, -1, cyc);
    chk("e_cycles", 64'(cyc), 64'd22);
    chk("e_cfgerr", 64'(cfg_err), 64'd0);
    chk("e_errcnt", 64'(err_count), 64'd0);
    w0 = wr_cnt; r0 = rd_cnt;
    run(1'b1, 14'd15999, 15'd1, 32'h12345678, -1, cyc);
    chk("f_cycles", 64'(cyc), 64'd3);
    chk("f_reads", 64'(rd_cnt - r0), 64'd1);
    chk("f_writes", 64'(wr_cnt - w0), 64'd0);
    chk("f_rdaddr", 64'(last_rd), 64'd15999);
    chk("f_errcnt", 64'(err_count), 64'd0);

    // Abort during READ, then re-check with a different seed
    mode = 1'b0; base = 14'd100; length = 15'd100; seed = 32'h11111111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (110) @(negedge clk);
    chk("g_in_read", 64'(mem_chipselect && !mem_write), 64'd1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    chk("g_rst_busy", 64'(busy), 64'd0);
    chk("g_rst_cs", 64'(mem_chipselect), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(1'b1, 14'd100, 15'd100, 32'h22222222, -1, cyc);
    chk("g_cycles", 64'(cyc), 64'd102);
    chk("g_reads", 64'(rd_cnt - r0), 64'd100);
    chk("g_writes", 64'(wr_cnt - w0), 64'd0);
    chk("g_errcnt", 64'(err_count), 64'd100);
    chk("g_fea", 64'(first_err_addr), 64'd100);
    repeat (3) @(negedge clk);
    chk("g_hold_errcnt", 64'(err_count), 64'd100);
    chk("g_hold_fev", 64'(first_err_valid), 64'd1);
    chk("g_hold_done", 64'(done), 64'd0);

    // Start pulsed mid-run must be ignored
    w0 = wr_cnt; r0 = rd_cnt;
    run(1'b1, 14'd0, 15'd16, 32'hA5A5A5A5, 5, cyc);
    chk("h_cycles", 64'(cyc), 64'd18);
    chk("h_reads", 64'(rd_cnt - r0), 64'd16);
    chk("h_writes", 64'(wr_cnt - w0), 64'd0);
    chk("h_lastaddr", 64'(last_rd), 64'd15);
    chk("h_errcnt", 64'(err_count), 64'd0);
    chk("h_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_bist_master.md
ONCHIP_MEM_BIST_MASTER -- requirements
Module: onchip_mem_bist_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, word-address width of the target memory.
REQ-002 The block SHALL have parameter DATA_W, default 64, data width in bits; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter DEPTH, default 16000, number of valid words in the target memory.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 mode  input  1  0 = write pattern then read and check; 1 = read and check only; sampled with start.
REQ-008 base  input  ADDR_W  first word address of the run; sampled with start.
REQ-009 length  input  ADDR_W+1  word count of the run; sampled with start.
REQ-010 seed  input  32  pattern seed; sampled with start.
REQ-011 busy, done, cfg_err  output  1 each  run in progress; one-cycle completion pulse; illegal configuration.
REQ-012 err_count  output  ADDR_W+1  number of miscompared words in the last run.
REQ-013 first_err_valid  output  1  a miscompare occurred in the last run.
REQ-014 first_err_addr  output  ADDR_W  address of the first miscompare.
REQ-015 mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken  output  ADDR_W/DATA_W/8, 1, 1, DATA_W, 1  Avalon-MM master command to the on-chip RAM slave.
REQ-016 mem_readdata  input  DATA_W  slave read data, valid exactly 1 cycle after a read command; there is no waitrequest.

Function
REQ-017 Expected word at address a SHALL be {seed ^ zext32(a), ~(seed ^ zext32(a))}.
REQ-018 The FSM SHALL have states IDLE, WRITE, READ, DRAIN, DONE.
REQ-019 IDLE + start: if length==0, the FSM SHALL go to DONE with no memory access; if base+length > DEPTH, it SHALL set cfg_err and go to DONE; otherwise it SHALL go to WRITE (mode 0) or READ (mode 1).
REQ-020 WRITE SHALL issue one write per cycle: chipselect=1, write=1, byteenable all ones, addresses base..base+length-1 ascending, then go to READ.
REQ-021 READ SHALL issue one read per cycle over the same addresses (chipselect=1, write=0), then go to DRAIN.
REQ-022 The block SHALL compare mem_readdata in the cycle after each read against the expected word for that read's address, which is registered alongside the command.
REQ-023 DRAIN SHALL last 1 cycle and compare the final read's data.
REQ-024 DONE SHALL last 1 cycle, pulse done=1, then return to IDLE.
REQ-025 Latency: mode 0 SHALL take 2*length+2 cycles from the start cycle to done inclusive of DONE; mode 1 SHALL take length+2 cycles.
REQ-026 busy SHALL be 1 in WRITE, READ, DRAIN and DONE, and 0 in IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 err_count, first_err_valid and cfg_err SHALL be cleared on an accepted start and SHALL hold their values after done until the next accepted start.
REQ-029 first_err_addr SHALL be captured only on the first miscompare of a run.
REQ-030 err_count SHALL NOT wrap, since its maximum is DEPTH.
REQ-031 mem_chipselect and mem_write SHALL be 0 in IDLE, DRAIN and DONE.
REQ-032 mem_clken SHALL be constant 1.
REQ-033 A run ending at address DEPTH-1 SHALL be legal, and the address SHALL NOT wrap.

Reset
REQ-034 While reset_n=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (mem_clken=1); this SHALL abort any run mid-operation.
REQ-035 The cycle after reset_n returns high, a start SHALL be accepted.

Structure
REQ-036 A shared package onchip_mem_bist_pkg SHALL hold the ADDR_W/DATA_W/DEPTH defaults, the state enum and the pattern function.
REQ-037 The block SHALL contain one sub-module, onchip_mem_bist_cmp: the registered expected word, the compare, err_count and first-error capture.

Verification (bench uses a behavioural 1-cycle-latency RAM model)
REQ-038 Mode 0, base=0, length=16, seed=0xA5A5A5A5 -> 16 writes then 16 reads, done at cycle 34, err_count=0, first_err_valid=0.
REQ-039 Same run with the model flipping bit 3 on reads of address 5 and address 9 -> err_count=2, first_err_addr=5.
REQ-040 base=15990, length=11 -> cfg_err=1, done 1 cycle after DONE entry, zero memory accesses; length=0 -> done with no accesses and cfg_err=0.
REQ-041 Mode 1, base=15999, length=1, after a prior mode-0 fill -> exactly one read at 15999, err_count=0, done at cycle 3.
REQ-042 reset_n low during READ at length=100, then start mode 1 with a different seed -> no access after reset, second run completes with err_count=100.
REQ-043 start pulsed while busy -> ignored; base/seed unchanged, no extra accesses.
